// File: rtl/axi_burst_slave.sv
// AXI4 burst slave over a word memory: queued AW/B write path and a two-state read FSM.
// Define AXI_SLAVE_ERR_CHECK_EN for SLVERR on out-of-range beats and WLAST mismatches.
module axi_burst_slave #(
  parameter int MEM_WORDS = 64,
  parameter int AW_DEPTH  = 4,
  parameter int B_DEPTH   = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic        S_AXI_AWLOCK,
  input  logic [3:0]  S_AXI_AWQOS,
  input  logic [3:0]  S_AXI_AWREGION,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [3:0]  S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic        S_AXI_ARLOCK,
  input  logic [3:0]  S_AXI_ARQOS,
  input  logic [3:0]  S_AXI_ARREGION,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [3:0]  S_AXI_RID,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);
  localparam int IDXW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int AWPW = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int BPW  = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int AWCW = $clog2(AW_DEPTH + 1);
  localparam int BCW  = $clog2(B_DEPTH + 1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, BURST_FIXED = 2'b00;

  typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] w;
    w = (addr >> 2) % 32'(MEM_WORDS);
    return w[IDXW-1:0];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

`ifdef AXI_SLAVE_ERR_CHECK_EN
  function automatic logic in_range(input logic [31:0] addr);
    return addr < 32'(MEM_WORDS * 4);
  endfunction
`endif

  function automatic logic [31:0] rd_data(input logic [31:0] addr);
`ifdef AXI_SLAVE_ERR_CHECK_EN
    if (!in_range(addr)) return 32'd0;
`endif
    return mem[word_idx(addr)];
  endfunction

  function automatic logic [1:0] rd_resp(input logic [31:0] addr);
`ifdef AXI_SLAVE_ERR_CHECK_EN
    if (!in_range(addr)) return SLVERR;
`endif
    return (addr == 32'd0) ? OKAY : OKAY;
  endfunction

  // run holds the ready outputs low until the first edge after reset release
  logic             run;
  logic [3:0]       aw_id_q    [AW_DEPTH];
  logic [31:0]      aw_addr_q  [AW_DEPTH];
  logic [7:0]       aw_len_q   [AW_DEPTH];
  logic [1:0]       aw_burst_q [AW_DEPTH];
  logic [AWPW-1:0]  aw_wp, aw_rp;
  logic [AWCW-1:0]  aw_cnt;
  logic [3:0]       b_id_q   [B_DEPTH];
  logic [1:0]       b_resp_q [B_DEPTH];
  logic [BPW-1:0]   b_wp, b_rp;
  logic [BCW-1:0]   b_cnt;
  logic [7:0]       w_beat;
  logic [31:0]      w_addr_q, w_addr;
  logic             w_err_q, w_beat_err, w_oor;
  logic             aw_push, w_fire, w_last, b_pop;
  logic [1:0]       b_resp_new;

  assign aw_push = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last  = w_fire && (w_beat == aw_len_q[aw_rp]);
  assign b_pop   = S_AXI_BVALID && S_AXI_BREADY;
  assign w_addr  = (w_beat == 8'd0) ? aw_addr_q[aw_rp] : w_addr_q;

  assign S_AXI_AWREADY = run && (aw_cnt < AWCW'(AW_DEPTH));
  assign S_AXI_WREADY  = run && (aw_cnt != '0) && (b_cnt < BCW'(B_DEPTH));
  assign S_AXI_BVALID  = (b_cnt != '0);
  assign S_AXI_BID     = S_AXI_BVALID ? b_id_q[b_rp] : 4'd0;
  assign S_AXI_BRESP   = S_AXI_BVALID ? b_resp_q[b_rp] : 2'd0;

`ifdef AXI_SLAVE_ERR_CHECK_EN
  assign w_oor      = !in_range(w_addr);
  assign w_beat_err = w_oor || (S_AXI_WLAST != (w_beat == aw_len_q[aw_rp]));
`else
  assign w_oor      = 1'b0;
  assign w_beat_err = 1'b0;
`endif
  assign b_resp_new = (w_err_q || w_beat_err) ? SLVERR : OKAY;

  always_ff @(posedge ACLK) begin
    if (ARESETn && w_fire && !w_oor) begin
      for (int i = 0; i < 4; i++)
        if (S_AXI_WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      run      <= 1'b0;
      aw_wp    <= '0;
      aw_rp    <= '0;
      aw_cnt   <= '0;
      b_wp     <= '0;
      b_rp     <= '0;
      b_cnt    <= '0;
      w_beat   <= 8'd0;
      w_addr_q <= 32'd0;
      w_err_q  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (aw_push) begin
        aw_id_q[aw_wp]    <= S_AXI_AWID;
        aw_addr_q[aw_wp]  <= S_AXI_AWADDR;
        aw_len_q[aw_wp]   <= S_AXI_AWLEN;
        aw_burst_q[aw_wp] <= S_AXI_AWBURST;
        aw_wp <= (aw_wp == AWPW'(AW_DEPTH - 1)) ? '0 : aw_wp + 1'b1;
      end
      if (w_last) begin
        w_beat  <= 8'd0;
        w_err_q <= 1'b0;
        aw_rp   <= (aw_rp == AWPW'(AW_DEPTH - 1)) ? '0 : aw_rp + 1'b1;
        b_id_q[b_wp]   <= aw_id_q[aw_rp];
        b_resp_q[b_wp] <= b_resp_new;
        b_wp <= (b_wp == BPW'(B_DEPTH - 1)) ? '0 : b_wp + 1'b1;
      end else if (w_fire) begin
        w_beat   <= w_beat + 8'd1;
        w_addr_q <= next_addr(w_addr, aw_burst_q[aw_rp]);
        w_err_q  <= w_err_q || w_beat_err;
      end
      if (b_pop) b_rp <= (b_rp == BPW'(B_DEPTH - 1)) ? '0 : b_rp + 1'b1;
      aw_cnt <= aw_cnt + AWCW'(aw_push) - AWCW'(w_last);
      b_cnt  <= b_cnt + BCW'(w_last) - BCW'(b_pop);
    end
  end

  r_state_t    r_state;
  logic [31:0] r_addr, r_next;
  logic [7:0]  r_len, r_beat;
  logic [1:0]  r_burst;

  assign r_next = next_addr(r_addr, r_burst);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RID     <= 4'd0;
      S_AXI_RRESP   <= 2'd0;
      S_AXI_RDATA   <= 32'd0;
      r_addr        <= 32'd0;
      r_len         <= 8'd0;
      r_beat        <= 8'd0;
      r_burst       <= 2'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            r_state       <= R_BURST;
            S_AXI_ARREADY <= 1'b0;
            r_addr        <= S_AXI_ARADDR;
            r_len         <= S_AXI_ARLEN;
            r_burst       <= S_AXI_ARBURST;
            r_beat        <= 8'd0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RID     <= S_AXI_ARID;
            S_AXI_RDATA   <= rd_data(S_AXI_ARADDR);
            S_AXI_RRESP   <= rd_resp(S_AXI_ARADDR);
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
          end
        end
        R_BURST: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              r_state       <= R_IDLE;
              S_AXI_ARREADY <= 1'b1;
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_RDATA   <= 32'd0;
              S_AXI_RRESP   <= 2'd0;
            end else begin
              r_addr      <= r_next;
              r_beat      <= r_beat + 8'd1;
              S_AXI_RDATA <= rd_data(r_next);
              S_AXI_RRESP <= rd_resp(r_next);
              S_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK, S_AXI_AWQOS,
                       S_AXI_AWREGION, S_AXI_ARSIZE, S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK,
                       S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_WLAST};
endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed bench for axi_burst_slave; expected B and R responses queued at issue, checked by monitors.
module tb_axi_burst_slave;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  S_AXI_AWID, S_AXI_ARID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWPROT, S_AXI_ARPROT;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST;
  logic [3:0]  S_AXI_AWCACHE, S_AXI_ARCACHE, S_AXI_AWQOS, S_AXI_ARQOS, S_AXI_AWREGION, S_AXI_ARREGION;
  logic        S_AXI_AWLOCK, S_AXI_ARLOCK;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [3:0]  S_AXI_BID, S_AXI_RID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [31:0] S_AXI_RDATA;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axi_burst_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWLOCK(S_AXI_AWLOCK), .S_AXI_AWQOS(S_AXI_AWQOS),
    .S_AXI_AWREGION(S_AXI_AWREGION), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARLOCK(S_AXI_ARLOCK), .S_AXI_ARQOS(S_AXI_ARQOS),
    .S_AXI_ARREGION(S_AXI_ARREGION), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t be;
  r_exp_t re;
  int errors = 0;
  int checks = 0;

  localparam logic [1:0] INCR = 2'b01, FIXED = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                       input logic last);
    rq.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  // B monitor: every accepted response must match the oldest expectation
  always @(negedge ACLK) begin
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else begin
        be = bq.pop_front();
        chk("bid", 64'(S_AXI_BID), 64'(be.id));
        chk("bresp", 64'(S_AXI_BRESP), 64'(be.resp));
      end
    end
  end

  always @(negedge ACLK) begin
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      chk("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
      if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        re = rq.pop_front();
        chk("rid", 64'(S_AXI_RID), 64'(re.id));
        chk("rdata", 64'(S_AXI_RDATA), 64'(re.data));
        chk("rresp", 64'(S_AXI_RRESP), 64'(re.resp));
        chk("rlast", 64'(S_AXI_RLAST), 64'(re.last));
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit hs = 0;
    int n = 0;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst;
    S_AXI_AWVALID = 1'b1;
    while (!hs && n < 300) begin
      @(negedge ACLK); hs = S_AXI_AWREADY;
      @(posedge ACLK); #1; n++;
    end
    S_AXI_AWVALID = 1'b0;
    if (!hs) chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit hs = 0;
    int n = 0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst;
    S_AXI_ARVALID = 1'b1;
    while (!hs && n < 300) begin
      @(negedge ACLK); hs = S_AXI_ARREADY;
      @(posedge ACLK); #1; n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!hs) chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit hs = 0;
    int n = 0;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
    while (!hs && n < 300) begin
      @(negedge ACLK); hs = S_AXI_WREADY;
      @(posedge ACLK); #1; n++;
    end
    S_AXI_WVALID = 1'b0;
    if (!hs) chk("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 500) begin
      @(posedge ACLK); #1; n++;
    end
    if (n >= 500) chk("drain_timeout", 64'(bq.size() + rq.size()), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
               S_AXI_RLAST, S_AXI_BID, S_AXI_BRESP, S_AXI_RID, S_AXI_RRESP, S_AXI_RDATA}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  logic [31:0] m0_exp, hi_exp;
  logic [1:0]  hi_resp;

  initial begin
    ARESETn = 1'b0;
    {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID} = '0;
    {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID} = '0;
    {S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK, S_AXI_AWQOS, S_AXI_AWREGION} = '0;
    {S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK, S_AXI_ARQOS, S_AXI_ARREGION} = '0;
    S_AXI_AWSIZE = 3'b010; S_AXI_ARSIZE = 3'b010;
    {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID} = '0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK) chk_idle_outputs("reset_outputs");
    @(posedge ACLK); #1; ARESETn = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    chk("ready_after_reset", {63'd0, S_AXI_AWREADY && S_AXI_ARREADY}, 64'd1);
    @(posedge ACLK); #1;

    // two outstanding 4-beat INCR bursts
    exp_b(4'd0, 2'b00); exp_b(4'd1, 2'b00);
    send_aw(4'd0, 32'h00, 8'd3, INCR);
    send_aw(4'd1, 32'h10, 8'd3, INCR);
    for (int b = 0; b < 2; b++)
      for (int n = 0; n < 4; n++) send_w(32'h10000000 + 32'(16*b + n), 4'hF, n == 3);
    drain();

    for (int n = 0; n < 4; n++) exp_r(4'd2, 32'h10000000 + 32'(n), 2'b00, n == 3);
    send_ar(4'd2, 32'h00, 8'd3, INCR);
    drain();
    for (int n = 0; n < 4; n++) exp_r(4'd3, 32'h10000010 + 32'(n), 2'b00, n == 3);
    send_ar(4'd3, 32'h10, 8'd3, INCR);
    drain();

    // B queue full stalls W; draining lets the fifth burst finish
    S_AXI_BREADY = 1'b0;
    for (int i = 0; i < 5; i++) exp_b(4'(4 + i), 2'b00);
    for (int i = 0; i < 4; i++) send_aw(4'(4 + i), 32'h40 + 32'(4*i), 8'd0, INCR);
    send_w(32'h20000000, 4'hF, 1'b1);
    send_aw(4'd8, 32'h50, 8'd0, INCR);
    for (int i = 1; i < 4; i++) send_w(32'h20000000 + 32'(i), 4'hF, 1'b1);
    S_AXI_WDATA = 32'h20000004; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("wready_bfull", 64'(S_AXI_WREADY), 64'd0);
      chk("bvalid_held", 64'(S_AXI_BVALID), 64'd1);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    send_w(32'h20000004, 4'hF, 1'b1);
    drain();
    for (int n = 0; n < 5; n++) exp_r(4'd9, 32'h20000000 + 32'(n), 2'b00, n == 4);
    send_ar(4'd9, 32'h40, 8'd4, INCR);
    drain();

    // partial strobes and a FIXED burst
    exp_b(4'd10, 2'b00); exp_b(4'd11, 2'b00); exp_b(4'd12, 2'b00);
    send_aw(4'd10, 32'hC0, 8'd0, INCR);
    send_w(32'h11111111, 4'hF, 1'b1);
    send_aw(4'd11, 32'hC0, 8'd0, INCR);
    send_w(32'hAABBCCDD, 4'b0011, 1'b1);
    send_aw(4'd12, 32'hC4, 8'd2, FIXED);
    send_w(32'h000000A1, 4'hF, 1'b0);
    send_w(32'h000000A2, 4'hF, 1'b0);
    send_w(32'h000000A3, 4'hF, 1'b1);
    drain();
    exp_r(4'd13, 32'h1111CCDD, 2'b00, 1'b0);
    exp_r(4'd13, 32'h000000A3, 2'b00, 1'b1);
    send_ar(4'd13, 32'hC0, 8'd1, INCR);
    drain();

    // address one past the end of memory
`ifdef AXI_SLAVE_ERR_CHECK_EN
    exp_b(4'd14, 2'b10);
    m0_exp = 32'h10000000; hi_exp = 32'h0; hi_resp = 2'b10;
`else
    exp_b(4'd14, 2'b00);
    m0_exp = 32'hDEADBEEF; hi_exp = 32'hDEADBEEF; hi_resp = 2'b00;
`endif
    send_aw(4'd14, 32'h100, 8'd0, INCR);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    drain();
    exp_r(4'd15, m0_exp, 2'b00, 1'b1);
    send_ar(4'd15, 32'h00, 8'd0, INCR);
    drain();
    exp_r(4'd0, hi_exp, hi_resp, 1'b1);
    send_ar(4'd0, 32'h100, 8'd0, INCR);
    drain();

    // reset in the middle of a write burst
    send_aw(4'd5, 32'h80, 8'd3, INCR);
    send_w(32'h30000000, 4'hF, 1'b0);
    send_w(32'h30000001, 4'hF, 1'b0);
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) chk_idle_outputs("midburst_reset_outputs");
    @(posedge ACLK); #1; ARESETn = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    chk("awready_after_release", 64'(S_AXI_AWREADY), 64'd1);
    chk("arready_after_release", 64'(S_AXI_ARREADY), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK) chk("no_bvalid_after_abort", 64'(S_AXI_BVALID), 64'd0);
    end
    @(posedge ACLK); #1;
    exp_b(4'd6, 2'b00);
    send_aw(4'd6, 32'h80, 8'd3, INCR);
    for (int n = 0; n < 4; n++) send_w(32'h40000000 + 32'(n), 4'hF, n == 3);
    drain();
    for (int n = 0; n < 4; n++) exp_r(4'd7, 32'h40000000 + 32'(n), 2'b00, n == 3);
    send_ar(4'd7, 32'h80, 8'd3, INCR);
    drain();

    repeat (3) @(posedge ACLK);
    chk("queues_empty", 64'(bq.size() + rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
